// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register hazard scoreboard with stall generation and stall counter
module hazard_scoreboard #(
   parameter int NUM_SRC  = 3,
   parameter int GR_NUM   = 32,
   parameter int GR_W     = 5,
   parameter int LOAD_LAT = 1,
   parameter int CSR_LAT  = 2,
   parameter int CNT_W    = 32
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    id_valid_i,
   input  logic [NUM_SRC*GR_W-1:0] id_src_no_i,
   input  logic [NUM_SRC-1:0]      id_src_en_i,
   input  logic [GR_W-1:0]         id_dst_no_i,
   input  logic                    id_dst_en_i,
   input  logic [1:0]              id_class_i,
   input  logic                    id_is_compare_i,
   input  logic                    long_done_i,
   input  logic [GR_W-1:0]         long_dst_no_i,
   input  logic                    flush_i,
   input  logic                    cnt_clr_i,
   output logic                    stall_o,
   output logic                    ex_bubble_o,
   output logic [GR_NUM-1:0]       busy_vec_o,
   output logic [CNT_W-1:0]        stall_cnt_o
);

   // Countdown must hold the largest reload value (CSR or LOAD latency + 1), never narrower than 2 bits.
   localparam int MAX_LOAD = ((LOAD_LAT > CSR_LAT) ? LOAD_LAT : CSR_LAT) + 1;
   localparam int CW       = ($clog2(MAX_LOAD + 1) < 2) ? 2 : $clog2(MAX_LOAD + 1);

   localparam logic [1:0] CLS_ALU  = 2'd0;
   localparam logic [1:0] CLS_LOAD = 2'd1;
   localparam logic [1:0] CLS_CSR  = 2'd2;
   localparam logic [1:0] CLS_LONG = 2'd3;

   logic [CW-1:0]     cnt [GR_NUM];
   logic [GR_NUM-1:0] long_busy;
   logic [GR_W-1:0]   src_no [NUM_SRC];
   logic              src_haz;
   logic              waw_haz;
   logic              issue;
   logic              dst_wr;
   logic [CW-1:0]     load_val;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      assign src_no[k] = id_src_no_i[k*GR_W +: GR_W];
   end

   // Source (RAW) and destination (WAW) hazard detection against current scoreboard state.
   always_comb begin
      src_haz = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (id_src_en_i[k] && (src_no[k] != '0)) begin
            if (long_busy[src_no[k]]) begin
               src_haz = 1'b1;
            end else if (id_is_compare_i) begin
               // Compare consumers read in ID, so they need the value one cycle earlier than EX consumers.
               if (cnt[src_no[k]] != '0) src_haz = 1'b1;
            end else begin
               if (cnt[src_no[k]] > CW'(1)) src_haz = 1'b1;
            end
         end
      end
      waw_haz = id_dst_en_i & long_busy[id_dst_no_i];
   end

   assign stall_o     = id_valid_i & ~flush_i & (src_haz | waw_haz);
   assign ex_bubble_o = stall_o | flush_i;
   assign issue       = id_valid_i & ~stall_o & ~flush_i;
   assign dst_wr      = issue & id_dst_en_i & (id_dst_no_i != '0);

   // Countdown reload value chosen by producer class; long ops are tracked by long_busy instead.
   always_comb begin
      load_val = CW'(1);
      case (id_class_i)
         CLS_ALU:  load_val = CW'(1);
         CLS_LOAD: load_val = CW'(LOAD_LAT + 1);
         CLS_CSR:  load_val = CW'(CSR_LAT + 1);
         CLS_LONG: load_val = '0;
         default:  load_val = CW'(1);
      endcase
   end

   // Per-register scoreboard update; reset and flush both wipe all in-flight producers.
   always_ff @(posedge clk) begin
      if (!rstn || flush_i) begin
         for (int r = 0; r < GR_NUM; r++) begin
            cnt[r] <= '0;
         end
         long_busy <= '0;
      end else begin
         cnt[0]       <= '0;
         long_busy[0] <= 1'b0;
         for (int r = 1; r < GR_NUM; r++) begin
            if (dst_wr && (id_dst_no_i == GR_W'(r))) begin
               cnt[r]       <= load_val;
               long_busy[r] <= (id_class_i == CLS_LONG);
            end else begin
               if (cnt[r] != '0) cnt[r] <= cnt[r] - CW'(1);
               if (long_done_i && (long_dst_no_i == GR_W'(r))) long_busy[r] <= 1'b0;
            end
         end
      end
   end

   // Busy view for normal consumers, derived from registered state only.
   always_comb begin
      for (int r = 0; r < GR_NUM; r++) begin
         busy_vec_o[r] = long_busy[r] | (cnt[r] > CW'(1));
      end
   end

   // Saturating stall-cycle counter; clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rstn || cnt_clr_i) begin
         stall_cnt_o <= '0;
      end else if (stall_o && !(&stall_cnt_o)) begin
         stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

   localparam int NUM_SRC  = 3;
   localparam int GR_NUM   = 32;
   localparam int GR_W     = 5;
   localparam int LOAD_LAT = 1;
   localparam int CSR_LAT  = 2;
   localparam int CNT_W    = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   localparam logic [1:0] ALU  = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] CSR  = 2'd2;
   localparam logic [1:0] LONG = 2'd3;

   logic                    clk;
   logic                    rstn;
   logic                    id_valid_i;
   logic [NUM_SRC*GR_W-1:0] id_src_no_i;
   logic [NUM_SRC-1:0]      id_src_en_i;
   logic [GR_W-1:0]         id_dst_no_i;
   logic                    id_dst_en_i;
   logic [1:0]              id_class_i;
   logic                    id_is_compare_i;
   logic                    long_done_i;
   logic [GR_W-1:0]         long_dst_no_i;
   logic                    flush_i;
   logic                    cnt_clr_i;
   logic                    stall_o;
   logic                    ex_bubble_o;
   logic [GR_NUM-1:0]       busy_vec_o;
   logic [CNT_W-1:0]        stall_cnt_o;

   hazard_scoreboard #(
      .NUM_SRC(NUM_SRC), .GR_NUM(GR_NUM), .GR_W(GR_W),
      .LOAD_LAT(LOAD_LAT), .CSR_LAT(CSR_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rstn(rstn), .id_valid_i(id_valid_i), .id_src_no_i(id_src_no_i),
      .id_src_en_i(id_src_en_i), .id_dst_no_i(id_dst_no_i), .id_dst_en_i(id_dst_en_i),
      .id_class_i(id_class_i), .id_is_compare_i(id_is_compare_i), .long_done_i(long_done_i),
      .long_dst_no_i(long_dst_no_i), .flush_i(flush_i), .cnt_clr_i(cnt_clr_i),
      .stall_o(stall_o), .ex_bubble_o(ex_bubble_o), .busy_vec_o(busy_vec_o),
      .stall_cnt_o(stall_cnt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: each register remembers the absolute cycle at which its value is fully available,
   // plus a pending flag for long ops.
   int  avail [GR_NUM];
   bit  lpend [GR_NUM];
   int  mcnt;
   int  t;
   int  checks;
   int  errors;
   bit  chk_en;
   int  last_stall;
   int  last_bubble;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_stall();
      int s;
      if (!id_valid_i || flush_i) return 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         s = int'(id_src_no_i[k*GR_W +: GR_W]);
         if (id_src_en_i[k] && s != 0) begin
            if (lpend[s]) return 1'b1;
            if (id_is_compare_i ? (t < avail[s]) : (t < avail[s] - 1)) return 1'b1;
         end
      end
      if (id_dst_en_i && lpend[id_dst_no_i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [GR_NUM-1:0] m_busy();
      logic [GR_NUM-1:0] b;
      for (int r = 0; r < GR_NUM; r++) b[r] = lpend[r] || (avail[r] - t > 1);
      return b;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < GR_NUM; r++) begin
         avail[r] = 0;
         lpend[r] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit st;
      int d;
      if (!rstn) begin
         model_clear();
         mcnt = 0;
      end else begin
         st = m_stall();
         if (flush_i) begin
            model_clear();
         end else begin
            if (long_done_i) lpend[long_dst_no_i] = 1'b0;
            d = int'(id_dst_no_i);
            if (id_valid_i && !st && id_dst_en_i && d != 0) begin
               lpend[d] = (id_class_i == LONG);
               case (id_class_i)
                  ALU:     avail[d] = t + 1 + 1;
                  LOAD:    avail[d] = t + 1 + LOAD_LAT + 1;
                  CSR:     avail[d] = t + 1 + CSR_LAT + 1;
                  default: avail[d] = 0;
               endcase
            end
         end
         if (cnt_clr_i) mcnt = 0;
         else if (st && mcnt < CNT_MAX) mcnt++;
      end
      t++;
   endtask

   task automatic cycle();
      bit es;
      @(negedge clk);
      last_stall  = int'(stall_o);
      last_bubble = int'(ex_bubble_o);
      if (chk_en) begin
         es = m_stall();
         chk("stall_o", stall_o, es);
         chk("ex_bubble_o", ex_bubble_o, es | flush_i);
         chk("busy_vec_o", busy_vec_o, m_busy());
         chk("stall_cnt_o", stall_cnt_o, mcnt);
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      id_valid_i      = 1'b0;
      id_src_no_i     = '0;
      id_src_en_i     = '0;
      id_dst_no_i     = '0;
      id_dst_en_i     = 1'b0;
      id_class_i      = ALU;
      id_is_compare_i = 1'b0;
      long_done_i     = 1'b0;
      long_dst_no_i   = '0;
      flush_i         = 1'b0;
      cnt_clr_i       = 1'b0;
   endtask

   task automatic set_id(input logic [GR_W-1:0] s0, input logic [GR_W-1:0] s1, input logic [GR_W-1:0] s2,
                         input logic [2:0] en, input logic [GR_W-1:0] dst, input logic den,
                         input logic [1:0] cls, input logic cmp);
      id_valid_i      = 1'b1;
      id_src_no_i     = {s2, s1, s0};
      id_src_en_i     = en;
      id_dst_no_i     = dst;
      id_dst_en_i     = den;
      id_class_i      = cls;
      id_is_compare_i = cmp;
   endtask

   task automatic run_instr(input string name, output int nst);
      bit done;
      done = 1'b0;
      nst  = 0;
      for (int i = 0; i < 40; i++) begin
         if (!done) begin
            cycle();
            if (last_stall != 0) nst++;
            else done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s issue_timeout actual=stalled expected=issued", name);
      end
      idle();
   endtask

   task automatic drain(input int n);
      idle();
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clr_cnt();
      idle();
      cnt_clr_i = 1'b1;
      cycle();
      cnt_clr_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      checks = 0;
      errors = 0;
      chk_en = 1'b0;
      t      = 0;
      mcnt   = 0;
      model_clear();
      idle();
      rstn = 1'b0;
      cycle();
      chk_en = 1'b1;
      cycle();
      rstn = 1'b1;
      chk("reset_stall", stall_o, 0);
      chk("reset_bubble", ex_bubble_o, 0);
      chk("reset_busy", busy_vec_o, 0);
      chk("reset_cnt", stall_cnt_o, 0);

      // ALU producer r4: normal consumer free, compare consumer one stall
      set_id(0, 0, 0, 3'b000, 4, 1, ALU, 0); run_instr("alu_r4", n);
      set_id(4, 0, 0, 3'b001, 0, 0, ALU, 0); run_instr("alu_norm", n);
      chk("alu_normal_stalls", n, 0);
      drain(3);
      set_id(0, 0, 0, 3'b000, 4, 1, ALU, 0); run_instr("alu_r4b", n);
      set_id(4, 0, 0, 3'b001, 0, 0, ALU, 1); run_instr("alu_cmp", n);
      chk("alu_compare_stalls", n, 1);

      // LOAD producer r5: 1 stall normal, 2 stalls compare, counter sums them
      drain(3);
      clr_cnt();
      set_id(0, 0, 0, 3'b000, 5, 1, LOAD, 0); run_instr("ld_r5", n);
      set_id(5, 0, 0, 3'b001, 0, 0, ALU, 0); run_instr("ld_norm", n);
      chk("load_normal_stalls", n, 1);
      drain(3);
      set_id(0, 0, 0, 3'b000, 5, 1, LOAD, 0); run_instr("ld_r5b", n);
      set_id(5, 0, 0, 3'b001, 0, 0, ALU, 1); run_instr("ld_cmp", n);
      chk("load_compare_stalls", n, 2);
      chk("load_stall_cnt", stall_cnt_o, 3);

      // Operand position and enable selection, CSR latency
      drain(3);
      set_id(0, 0, 0, 3'b000, 6, 1, LOAD, 0); run_instr("ld_r6", n);
      set_id(0, 0, 6, 3'b100, 0, 0, ALU, 0); run_instr("src2", n);
      chk("src2_stalls", n, 1);
      drain(3);
      set_id(0, 0, 0, 3'b000, 6, 1, LOAD, 0); run_instr("ld_r6b", n);
      set_id(6, 0, 0, 3'b000, 0, 0, ALU, 0); run_instr("src_disabled", n);
      chk("src_disabled_stalls", n, 0);
      drain(3);
      set_id(0, 0, 0, 3'b000, 8, 1, CSR, 0); run_instr("csr_r8", n);
      set_id(0, 8, 0, 3'b010, 0, 0, ALU, 0); run_instr("csr_norm", n);
      chk("csr_normal_stalls", n, 2);

      // LONG producer r7: reader waits for long_done, then WAW writer waits too
      drain(3);
      set_id(0, 0, 0, 3'b000, 7, 1, LONG, 0); run_instr("long_r7", n);
      set_id(7, 0, 0, 3'b001, 0, 0, ALU, 0);
      repeat (4) cycle();
      chk("long_reader_stalled", last_stall, 1);
      chk("long_busy7", busy_vec_o[7], 1);
      long_done_i = 1'b1; long_dst_no_i = 7;
      cycle();
      chk("long_done_cycle_stall", last_stall, 1);
      long_done_i = 1'b0;
      cycle();
      chk("long_after_done", last_stall, 0);
      idle();
      set_id(0, 0, 0, 3'b000, 7, 1, LONG, 0); run_instr("long_r7b", n);
      set_id(0, 0, 0, 3'b000, 7, 1, ALU, 0);
      repeat (3) cycle();
      chk("waw_stall", last_stall, 1);
      long_done_i = 1'b1; long_dst_no_i = 7;
      cycle();
      long_done_i = 1'b0;
      cycle();
      chk("waw_after_done", last_stall, 0);

      // r0 is never marked
      drain(3);
      set_id(0, 0, 0, 3'b000, 0, 1, LOAD, 0); run_instr("ld_r0", n);
      set_id(0, 0, 0, 3'b001, 0, 0, ALU, 1);
      chk("r0_busy", busy_vec_o[0], 0);
      run_instr("r0_reader", n);
      chk("r0_stalls", n, 0);

      // Flush wipes long_busy[9] and cnt[3]=2
      drain(3);
      set_id(0, 0, 0, 3'b000, 9, 1, LONG, 0); run_instr("long_r9", n);
      set_id(0, 0, 0, 3'b000, 3, 1, LOAD, 0); run_instr("ld_r3", n);
      chk("pre_flush_busy", busy_vec_o, 32'h0000_0208);
      set_id(9, 0, 0, 3'b001, 0, 0, ALU, 1);
      flush_i = 1'b1;
      cycle();
      chk("flush_stall", last_stall, 0);
      chk("flush_bubble", last_bubble, 1);
      idle();
      chk("post_flush_busy", busy_vec_o, 0);
      set_id(9, 3, 0, 3'b011, 0, 0, ALU, 1); run_instr("post_flush_reader", n);
      chk("post_flush_stalls", n, 0);

      // Counter saturation, then clear together with a stall
      drain(2);
      clr_cnt();
      set_id(0, 0, 0, 3'b000, 10, 1, LONG, 0); run_instr("long_r10", n);
      set_id(10, 0, 0, 3'b001, 0, 0, ALU, 0);
      repeat (20) cycle();
      chk("cnt_saturated", stall_cnt_o, 15);
      cnt_clr_i = 1'b1;
      cycle();
      cnt_clr_i = 1'b0;
      chk("cnt_clear_wins", stall_cnt_o, 0);
      chk("clear_cycle_stalled", last_stall, 1);
      long_done_i = 1'b1; long_dst_no_i = 10;
      cycle();
      long_done_i = 1'b0;
      chk("cnt_after_one_stall", stall_cnt_o, 1);

      // Reset overrides issue and done in the same cycle
      idle();
      set_id(0, 0, 0, 3'b000, 11, 1, LONG, 0);
      long_done_i = 1'b1; long_dst_no_i = 10;
      rstn = 1'b0;
      cycle();
      rstn = 1'b1;
      idle();
      chk("reset_override_busy", busy_vec_o, 0);
      chk("reset_override_cnt", stall_cnt_o, 0);
      set_id(0, 0, 0, 3'b000, 11, 1, ALU, 0); run_instr("post_reset_waw", n);
      chk("post_reset_waw_stalls", n, 0);
      drain(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
